// File: rtl/dcache_if.sv
// dcache_if: single-beat request/ready bus between dcache and its backing data memory
interface dcache_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic mem_req;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate data cache; define DCACHE_STATS_EN for hit/miss counters
module dcache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic cpu_we,
  input  logic cpu_re,
  input  logic cpu_bytemode,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic stall,
  dcache_mem_if.master bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - IW - 2;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;
  state_e state_q, state_d;
  logic done_q, done_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [SETS];
  logic [TW-1:0] tag_d [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] data_d [SETS];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, line, merged;
  logic [3:0] strb_q, strb_d;
  logic [IW-1:0] idx, req_idx;
  logic [TW-1:0] req_tag;
  logic hit, req_hit, store, miss;

  assign idx = cpu_addr[IW+1:2];
  assign req_idx = addr_q[IW+1:2];
  assign req_tag = addr_q[ADDR_WIDTH-1:IW+2];
  assign hit = valid_q[idx] && tag_q[idx] == cpu_addr[ADDR_WIDTH-1:IW+2];
  assign req_hit = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  assign store = cpu_we && !done_q;
  assign miss = !cpu_we && cpu_re && !hit;
  assign line = data_q[idx];
  assign cpu_rdata = cpu_bytemode ? DATA_WIDTH'(line[8*cpu_addr[1:0] +: 8]) : line;
  assign bus.mem_req = state_q != IDLE;
  assign bus.mem_we = state_q == WRITE;
  assign bus.mem_addr = state_q != IDLE ? addr_q : '0;
  assign bus.mem_wdata = state_q == WRITE ? wdata_q : '0;
  assign bus.mem_wstrb = state_q == WRITE ? strb_q : '0;

  always_comb begin
    merged = data_q[req_idx];
    for (int i = 0; i < 4; i++)
      if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    stall = 1'b1;
    if (state_q == IDLE) begin
      stall = store || miss;
      state_d = store ? WRITE : miss ? REFILL : IDLE;
      addr_d = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
      wdata_d = cpu_bytemode ? {4{cpu_wdata[7:0]}} : cpu_wdata;
      strb_d = cpu_bytemode ? 4'b0001 << cpu_addr[1:0] : 4'b1111;
    end else if (bus.mem_ready) begin
      state_d = IDLE;
      done_d = state_q == WRITE;
      if (state_q == REFILL) begin
        valid_d[req_idx] = 1'b1;
        tag_d[req_idx] = req_tag;
        data_d[req_idx] = bus.mem_rdata;
      end else if (req_hit) begin
        data_d[req_idx] = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    data_q <= data_d;
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    strb_q <= strb_d;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  assign hit_d = hit_q + 32'(state_q == IDLE && !cpu_we && cpu_re && hit);
  assign miss_d = miss_q + 32'(state_q == IDLE && miss);
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  assign hit_count = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scoreboard bench for dcache against a tag-map plus backing-memory reference model
module tb_dcache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, hit_count, miss_count;
  logic cpu_we = 1'b0, cpu_re = 1'b0, cpu_bytemode = 1'b0, stall;
  dcache_mem_if bus ();
  dcache dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_bytemode(cpu_bytemode), .cpu_rdata(cpu_rdata), .stall(stall),
    .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
  } mx_t;
  mx_t mem_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [23:0] tag_m [int];
  int checks = 0, failures = 0, wait_cycles = 0, wcnt = 0, req_n = 0, exp_hit = 0, exp_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check_counts();
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, exp_hit);
    check("miss_count", miss_count, exp_miss);
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
`endif
  endtask

  // backing memory with programmable wait states; also the memory-side scoreboard monitor
  initial begin
    mx_t x;
    logic [31:0] w;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.mem_req) begin
        if (wcnt == 0) req_n++;
        if (wcnt >= wait_cycles) begin
          bus.mem_ready = 1'b1;
          wcnt = 0;
          if (mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_req: got addr %h we %b, expected no request", bus.mem_addr, bus.mem_we);
          end else begin
            x = mem_q.pop_front();
            check("mem_we", 32'(bus.mem_we), 32'(x.we));
            check("mem_addr", bus.mem_addr, x.addr);
            if (x.we) begin
              check("mem_wdata", bus.mem_wdata, x.wdata);
              check("mem_wstrb", 32'(bus.mem_wstrb), 32'(x.wstrb));
            end
          end
          if (bus.mem_we) begin
            w = mem_word(bus.mem_addr);
            for (int i = 0; i < 4; i++)
              if (bus.mem_wstrb[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            mem_m[bus.mem_addr] = w;
          end else begin
            bus.mem_rdata = mem_word(bus.mem_addr);
          end
        end else begin
          bus.mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && cpu_re && !cpu_we && !stall) begin
      if (ld_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load_accept: got data %h at %h, expected no load", cpu_rdata, cpu_addr);
      end else begin
        check("cpu_rdata", cpu_rdata, ld_q.pop_front());
      end
    end
  end

  task automatic op(input logic we, input logic re, input logic bm, input logic [31:0] a,
                    input logic [31:0] wd, input int w);
    logic [31:0] wa, word;
    logic [23:0] tg;
    int idx, n, exp_stall;
    mx_t x;
    wa = {a[31:2], 2'b00};
    idx = int'(a[7:2]);
    tg = a[31:8];
    exp_stall = 0;
    if (we) begin
      x.we = 1'b1;
      x.addr = wa;
      x.wstrb = bm ? 4'(1 << a[1:0]) : 4'hf;
      x.wdata = bm ? {4{wd[7:0]}} : wd;
      mem_q.push_back(x);
      exp_stall = w + 2;
    end else if (re) begin
      if (!(tag_m.exists(idx) && tag_m[idx] == tg)) begin
        x.we = 1'b0;
        x.addr = wa;
        x.wdata = '0;
        x.wstrb = '0;
        mem_q.push_back(x);
        tag_m[idx] = tg;
        exp_miss++;
        exp_stall = w + 2;
      end
      exp_hit++;
      word = mem_word(wa);
      ld_q.push_back(bm ? 32'(word[8*a[1:0] +: 8]) : word);
    end
    wait_cycles = w;
    @(posedge clk);
    #1;
    cpu_we = we;
    cpu_re = re;
    cpu_bytemode = bm;
    cpu_addr = a;
    cpu_wdata = wd;
    n = 0;
    while (n <= 200) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("stall_cycles", n, exp_stall);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tag_m.delete();
    exp_hit = 0;
    exp_miss = 0;
  endtask

  initial begin
    int n0, k;
    logic [31:0] a;
    logic bm;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check_counts();
    mem_m[32'h100] = 32'hDEADBEEF;
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 3);
    n0 = req_n;
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2);
    check("repeat_load_no_req", req_n, n0);
    do_reset();
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1);
    op(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 0);
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2);
    check_counts();
    mem_m[32'h140] = 32'h11223344;
    op(1'b0, 1'b1, 1'b0, 32'h140, 32'h0, 1);
    op(1'b1, 1'b0, 1'b1, 32'h141, 32'hAB, 1);
    op(1'b0, 1'b1, 1'b1, 32'h141, 32'h0, 0);
    op(1'b1, 1'b0, 1'b0, 32'h300, 32'h12345678, 0);
    op(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1);
    n0 = req_n;
    op(1'b1, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 2);
    check("we_re_single_req", req_n, n0 + 1);
    check_counts();
    wait_cycles = 50;
    @(posedge clk);
    #1;
    cpu_re = 1'b1;
    cpu_addr = 32'h0000FF04;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_refill", 32'(stall), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_re = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midreset_mem_req", 32'(bus.mem_req), 32'd0);
    check("midreset_stall", 32'(stall), 32'd0);
    check("midreset_hit_count", hit_count, 32'd0);
    check("midreset_miss_count", miss_count, 32'd0);
    tag_m.delete();
    exp_hit = 0;
    exp_miss = 0;
    n0 = req_n;
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1);
    check("post_reset_refill", req_n, n0 + 1);
    check_counts();
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 5));
      bm = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | (bm ? $urandom_range(0, 3) : 0);
      op(k < 2, k >= 1, bm, a, $urandom, int'($urandom_range(0, 3)));
      if (i % 100 == 99) check_counts();
    end
    check_counts();
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("ld_q_drained", ld_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's ALU/regfile outputs and a multi-cycle backing data memory. It returns hits combinationally in the access cycle. It stalls the core through `stall` on read misses and on every store while a single-beat request/ready handshake to memory completes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte-address width.
- `SETS`, 64: number of one-word lines; a power of two, at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on rising `clk`.
- `cpu_addr`  in  ADDR_WIDTH: byte address (ALU result).
- `cpu_wdata`  in  DATA_WIDTH: store data (RD2).
- `cpu_we`  in  1: store request.
- `cpu_re`  in  1: load request.
- `cpu_bytemode`  in  1: 1 = byte access, 0 = word access (AddrMode).
- `cpu_rdata`  out  DATA_WIDTH: load data, valid when `cpu_re` is 1 and `stall` is 0.
- `stall`  out  1: 1 = core must hold PC and inputs stable.
- `mem_req`  out  1: memory request valid.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  ADDR_WIDTH: word-aligned address, with bits [1:0] = 0.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `mem_wstrb`  out  4: byte enables for writes.
- `mem_ready`  in  1: memory accepts the request and completes it in this cycle. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_WIDTH: read data.
- `hit_count`  out  32: load hit counter (see Configuration).
- `miss_count`  out  32: load miss counter (see Configuration).

## Operation
- Address split:
  - index = `cpu_addr[$clog2(SETS)+1:2]`
  - tag = `cpu_addr[ADDR_WIDTH-1:$clog2(SETS)+2]`
  - byte offset = `cpu_addr[1:0]`
- Per-line state: valid bit, tag, 32-bit data word.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - If `cpu_we`=1: `stall`=1, next state WRITE. A store takes priority over a simultaneous `cpu_re`.
  - Else if `cpu_re`=1 and hit (valid and tag match): `stall`=0 and `cpu_rdata` is driven combinationally. State stays IDLE.
  - Else if `cpu_re`=1 and miss: `stall`=1, next state REFILL. Latch the word-aligned address.
  - Otherwise: `stall`=0.
- REFILL:
  - Outputs: `mem_req`=1, `mem_we`=0, `stall`=1.
  - On `mem_ready`: write `mem_rdata` into the line, set valid, write the tag, and go to IDLE.
- WRITE:
  - Outputs: `mem_req`=1, `mem_we`=1, `stall`=1.
  - Word mode: `mem_wstrb`=4'b1111, `mem_wdata`=`cpu_wdata`.
  - Byte mode: `mem_wstrb`=one-hot at the byte offset, `mem_wdata`={4{`cpu_wdata[7:0]`}}.
  - On `mem_ready`: if the line hits, merge the strobed bytes into it; on a miss the line is unchanged (no allocate). Go to IDLE.
- Load data:
  - Word mode: the full word.
  - Byte mode: the selected byte, zero-extended.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` stay stable while `mem_req`=1 and `mem_ready`=0.
- `mem_ready` is ignored in IDLE.
- When `mem_req`=0: `mem_addr`, `mem_wdata` and `mem_wstrb` are 0.

## Timing
- Reset (`rst`=0 at a rising edge):
  - State returns to IDLE and every valid bit clears.
  - `mem_req`=0, `mem_we`=0, `mem_wstrb`=0 and `stall`=0 from the next cycle.
  - Counters reset to 0.
  - An in-flight request is abandoned; memory must tolerate `mem_req` dropping.
- Load hit: 0 stall cycles.
- Load miss detected in cycle N:
  - REFILL is entered at N+1.
  - If `mem_ready` arrives in cycle M (M ≥ N+1), the state is IDLE at M+1 and the access hits with `stall`=0.
  - Stall cycles = M−N+1, minimum 2.
- Store in cycle N: WRITE is entered at N+1. Ready in cycle M gives `stall`=0 at M+1, minimum 2 stall cycles.
- The line update and the state transition take effect on the same edge.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments once per load accepted as a hit in IDLE.
  - `miss_count` increments once per load miss, on the IDLE→REFILL transition.
  - Both counters wrap at 2^32.
  - Post-refill re-hits count as hits.
- `DCACHE_STATS_EN` undefined: `hit_count` and `miss_count` are tied to 0 and no counter flops are generated.

## Test plan
- Reset, then load word 0x100 with memory returning 0xDEADBEEF after 3 wait cycles:
  - `stall` is high for 5 cycles, then `cpu_rdata`=0xDEADBEEF.
  - A repeat load has `stall`=0 and no `mem_req`.
- Conflict miss: load 0x100, then 0x200 (same index with SETS=64), then 0x100. Expect three refills and `miss_count`=3 with stats enabled.
- Byte store of 0xAB to 0x101 after a word load of 0x11223344:
  - Expect `mem_wstrb`=4'b0010 and `mem_wdata`=0xABABABAB.
  - A following byte load at 0x101 hits and returns 0x000000AB.
- Store to an uncached address 0x300, then load 0x300. The store leaves the line invalid, and the load misses (refill observed).
- `cpu_we`=1 and `cpu_re`=1 together: only a write request is issued and no refill occurs.
- `rst`=0 asserted mid-REFILL:
  - The next cycle has `mem_req`=0, `stall`=0, and counters at 0.
  - A previously cached address now misses.
